// File: rtl/booth_pkg.sv
// Shared types and constants for the parametrised radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Counter must hold WIDTH+1, the number of Booth steps per operation.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_multiplier_n_if.sv
// Request/response bundle of the Booth multiplier: start handshake, operands, result.
interface booth_multiplier_n_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplier;
    logic [WIDTH-1:0]       multiplicand;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, multiplier, multiplicand,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplier, multiplicand,
        output busy, done, product
    );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic
// right shift of {A, Q, q_1}.
module booth_step
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic signed [WIDTH+1:0] a_i,
    input  logic signed [WIDTH:0]   q_i,
    input  logic                    q1_i,
    input  logic signed [WIDTH+1:0] m_i,
    output logic signed [WIDTH+1:0] a_o,
    output logic signed [WIDTH:0]   q_o,
    output logic                    q1_o
);

    logic signed [WIDTH+1:0] sum;

    always_comb begin
        sum = a_i;
        case ({q_i[0], q1_i})
            BOOTH_ADD: sum = a_i + m_i;
            BOOTH_SUB: sum = a_i - m_i;
            default:   sum = a_i;
        endcase
        // A's sign bit is replicated so the guard bit survives the shift.
        {a_o, q_o, q1_o} = {sum[WIDTH+1], sum, q_i};
    end

endmodule

// File: rtl/booth_multiplier_n.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake and
// fixed WIDTH+1 cycle latency; product register holds the last result.
module booth_multiplier_n
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    booth_multiplier_n_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int AW    = WIDTH + 2;
    localparam int QW    = WIDTH + 1;

    booth_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic signed [AW-1:0]  a_q, a_d, m_q, m_d, a_step;
    logic signed [QW-1:0]  q_q, q_d, q_step;
    logic                  q1_q, q1_d, q1_step;
    logic [2*WIDTH-1:0]    prod_q, prod_d;
    logic [AW+QW-1:0]      aq_step;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a_i  (a_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .m_i  (m_q),
        .a_o  (a_step),
        .q_o  (q_step),
        .q1_o (q1_step)
    );

    assign aq_step = {a_step, q_step};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = CALC;
                    cnt_d   = CNT_W'(WIDTH + 1);
                    a_d     = '0;
                    q1_d    = 1'b0;
                    // Extra top bits make unsigned operands non-negative in signed arithmetic.
                    if (bus.signed_mode) begin
                        m_d = {{2{bus.multiplicand[WIDTH-1]}}, bus.multiplicand};
                        q_d = {bus.multiplier[WIDTH-1], bus.multiplier};
                    end else begin
                        m_d = {2'b00, bus.multiplicand};
                        q_d = {1'b0, bus.multiplier};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                a_d   = a_step;
                q_d   = q_step;
                q1_d  = q1_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                    prod_d  = aq_step[2*WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.busy    = (state_q == CALC);
    assign bus.done    = (state_q == DONE);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_booth_multiplier_n.sv
// Bench for booth_multiplier_n at WIDTH 4, 8 and 16 against an arithmetic model.
module tb_booth_multiplier_n;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 CLK = ~CLK;

    booth_multiplier_n_if #(.WIDTH(4))  b4 ();
    booth_multiplier_n_if #(.WIDTH(8))  b8 ();
    booth_multiplier_n_if #(.WIDTH(16)) b16 ();

    booth_multiplier_n #(.WIDTH(4))  dut4  (.CLK(CLK), .RST(RST), .bus(b4));
    booth_multiplier_n #(.WIDTH(8))  dut8  (.CLK(CLK), .RST(RST), .bus(b8));
    booth_multiplier_n #(.WIDTH(16)) dut16 (.CLK(CLK), .RST(RST), .bus(b16));

    typedef struct {
        int          w;
        logic        sm;
        logic [15:0] q;
        logic [15:0] m;
        logic [31:0] e;
    } vec_t;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input int w, input logic s, input logic sm,
                         input logic [15:0] q, input logic [15:0] m);
        case (w)
            4: begin
                b4.start = s; b4.signed_mode = sm;
                b4.multiplier = q[3:0]; b4.multiplicand = m[3:0];
            end
            8: begin
                b8.start = s; b8.signed_mode = sm;
                b8.multiplier = q[7:0]; b8.multiplicand = m[7:0];
            end
            default: begin
                b16.start = s; b16.signed_mode = sm;
                b16.multiplier = q; b16.multiplicand = m;
            end
        endcase
    endtask

    function automatic logic [31:0] get_prod(input int w);
        case (w)
            4:       return 32'(b4.product);
            8:       return 32'(b8.product);
            default: return 32'(b16.product);
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            4:       return b4.done;
            8:       return b8.done;
            default: return b16.done;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return b4.busy;
            8:       return b8.busy;
            default: return b16.busy;
        endcase
    endfunction

    // Reference: interpret operands as integers of the chosen signedness, multiply, keep 2*w bits.
    function automatic logic [31:0] model(input int w, input logic sm,
                                          input logic [15:0] q, input logic [15:0] m);
        longint md, qv, mv, p;
        md = longint'(1) << w;
        qv = longint'(q) & (md - 1);
        mv = longint'(m) & (md - 1);
        if (sm && qv >= md / 2) qv = qv - md;
        if (sm && mv >= md / 2) mv = mv - md;
        p = (qv * mv) & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    // Issues one operation and waits for done; cnt counts edges after the accept edge.
    task automatic run_op(input int w, input logic sm, input logic [15:0] q, input logic [15:0] m,
                          output logic [31:0] got, output int lat,
                          output bit stable, output bit busy_ok);
        logic [31:0] prev;
        int          cnt;
        prev    = get_prod(w);
        stable  = 1'b1;
        busy_ok = 1'b1;
        drive(w, 1'b1, sm, q, m);
        tick();
        drive(w, 1'b0, ~sm, 16'($urandom), 16'($urandom));
        cnt = 0;
        while (get_done(w) !== 1'b1 && cnt < 200) begin
            if (get_prod(w) !== prev) stable = 1'b0;
            if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
            tick();
            cnt++;
        end
        if (get_busy(w) !== 1'b0) busy_ok = 1'b0;
        got = get_prod(w);
        lat = cnt;
    endtask

    task automatic test_reset();
        int ws[3] = '{4, 8, 16};
        RST = 1'b1;
        drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(8, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(16, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        foreach (ws[i]) begin
            total_cnt++;
            if (get_busy(ws[i]) !== 1'b0)
                $display("FAIL reset_busy w=%0d got=%b exp=0", ws[i], get_busy(ws[i]));
            else pass_cnt++;
            total_cnt++;
            if (get_done(ws[i]) !== 1'b0)
                $display("FAIL reset_done w=%0d got=%b exp=0", ws[i], get_done(ws[i]));
            else pass_cnt++;
            total_cnt++;
            if (get_prod(ws[i]) !== 32'h0)
                $display("FAIL reset_product w=%0d got=%h exp=0", ws[i], get_prod(ws[i]));
            else pass_cnt++;
        end
        RST = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        vec_t        v[7];
        logic [31:0] got;
        int          lat;
        bit          st, bz;
        v = '{
            '{4,  1'b1, 16'h000F, 16'h000F, 32'h0001},
            '{4,  1'b0, 16'h000F, 16'h000F, 32'h00E1},
            '{4,  1'b1, 16'h000F, 16'h0002, 32'h00FE},
            '{4,  1'b1, 16'h0008, 16'h0008, 32'h0040},
            '{8,  1'b1, 16'h0080, 16'h0080, 32'h4000},
            '{8,  1'b0, 16'h00FF, 16'h00FF, 32'hFE01},
            '{16, 1'b1, 16'h8000, 16'h8000, 32'h40000000}
        };
        foreach (v[i]) begin
            run_op(v[i].w, v[i].sm, v[i].q, v[i].m, got, lat, st, bz);
            total_cnt++;
            if (got !== v[i].e)
                $display("FAIL directed_product[%0d] got=%h exp=%h", i, got, v[i].e);
            else pass_cnt++;
            total_cnt++;
            if (lat !== v[i].w + 1)
                $display("FAIL directed_latency[%0d] got=%0d exp=%0d", i, lat, v[i].w + 1);
            else pass_cnt++;
            total_cnt++;
            if (!bz)
                $display("FAIL directed_busy[%0d] got=bad exp=busy_only_in_calc", i);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        drive(4, 1'b1, 1'b1, 16'h3, 16'h5);
        tick();
        drive(4, 1'b0, 1'b1, 16'h0, 16'h0);
        tick();
        tick();
        drive(4, 1'b1, 1'b0, 16'h7, 16'h7);
        tick();
        drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
        cnt = 3;
        while (b4.done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        total_cnt++;
        if (b4.product !== 8'h0F) $display("FAIL ignored_start_product got=%h exp=0f", b4.product);
        else pass_cnt++;
        total_cnt++;
        if (cnt !== 5) $display("FAIL ignored_start_latency got=%0d exp=5", cnt);
        else pass_cnt++;

        // start held in the DONE cycle is accepted on the next edge.
        drive(4, 1'b1, 1'b1, 16'hD, 16'h6);
        tick();
        total_cnt++;
        if (b4.busy !== 1'b1) $display("FAIL b2b_accept_busy got=%b exp=1", b4.busy);
        else pass_cnt++;
        drive(4, 1'b0, 1'b1, 16'h0, 16'h0);
        cnt = 1;
        while (b4.done !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        total_cnt++;
        if (b4.product !== 8'hEE) $display("FAIL b2b_product got=%h exp=ee", b4.product);
        else pass_cnt++;
        total_cnt++;
        if (cnt !== 6) $display("FAIL b2b_gap got=%0d exp=6", cnt);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_calc();
        bit          seen;
        logic [31:0] got;
        int          lat;
        bit          st, bz;
        drive(4, 1'b1, 1'b0, 16'hD, 16'hB);
        tick();
        drive(4, 1'b0, 1'b0, 16'h0, 16'h0);
        tick();
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        total_cnt++;
        if ({b4.busy, b4.done} !== 2'b00)
            $display("FAIL midreset_ctrl got=%b%b exp=00", b4.busy, b4.done);
        else pass_cnt++;
        total_cnt++;
        if (b4.product !== 8'h00) $display("FAIL midreset_product got=%h exp=00", b4.product);
        else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (b4.done === 1'b1) seen = 1'b1;
            tick();
        end
        total_cnt++;
        if (seen) $display("FAIL midreset_no_done got=done_seen exp=none");
        else pass_cnt++;

        RST = 1'b1;
        drive(4, 1'b1, 1'b1, 16'h3, 16'h3);
        tick();
        RST = 1'b0;
        drive(4, 1'b0, 1'b1, 16'h0, 16'h0);
        total_cnt++;
        if (b4.busy !== 1'b0) $display("FAIL reset_beats_start got=%b exp=0", b4.busy);
        else pass_cnt++;

        run_op(4, 1'b1, 16'h5, 16'hA, got, lat, st, bz);
        total_cnt++;
        if (got !== 32'hE2) $display("FAIL post_reset_product got=%h exp=e2", got);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 5) $display("FAIL post_reset_latency got=%0d exp=5", lat);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int          ws[3] = '{4, 8, 16};
        int          w, lat;
        logic        sm;
        logic [15:0] q, m;
        logic [31:0] got, exp_p;
        bit          st, bz;
        for (int i = 0; i < 1000; i++) begin
            w     = ws[$urandom_range(0, 2)];
            sm    = 1'($urandom_range(0, 1));
            q     = 16'($urandom);
            m     = 16'($urandom);
            exp_p = model(w, sm, q, m);
            run_op(w, sm, q, m, got, lat, st, bz);
            total_cnt++;
            if (got !== exp_p)
                $display("FAIL rand_product[%0d] w=%0d sm=%b q=%h m=%h got=%h exp=%h",
                         i, w, sm, q, m, got, exp_p);
            else pass_cnt++;
            total_cnt++;
            if (lat !== w + 1)
                $display("FAIL rand_latency[%0d] w=%0d got=%0d exp=%0d", i, w, lat, w + 1);
            else pass_cnt++;
            total_cnt++;
            if (!st || !bz)
                $display("FAIL rand_stable[%0d] w=%0d got=stable%0b_busy%0b exp=stable1_busy1",
                         i, w, st, bz);
            else pass_cnt++;
            if ($urandom_range(0, 3) == 0) tick();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/booth_multiplier_n.md
# booth_multiplier_n

Parametrised sequential radix-2 Booth multiplier. Successor to the fixed 4-bit `booth_multiplier`: operand width is a parameter, a per-operation signed/unsigned mode is added, and a start/busy/done handshake with fixed latency replaces free-running operation. It sits on the datapath as a shared multi-cycle multiply unit, and its product register holds the last result until the next completion.

## Interface
- `WIDTH`, 8: operand width in bits (≥2); product is `2*WIDTH` bits.
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `start`  in  1  request; accepted only when `busy`=0.
- `signed_mode`  in  1  1 = two's-complement operands; 0 = unsigned. Sampled with `start`.
- `multiplier`  in  WIDTH  operand Q; sampled on the accept edge.
- `multiplicand`  in  WIDTH  operand M; sampled on the accept edge.
- `busy`  out  1  high while in CALC.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle onward.
- `product`  out  2*WIDTH  result register; holds until the next completion.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE to CALC on `start`=1.
  - DONE to CALC on `start`=1; otherwise DONE to IDLE.
  - CALC to DONE when the step counter reaches 0.
- Operand extension on accept:
  - signed: sign-extend M to WIDTH+2 bits and Q to WIDTH+1 bits.
  - unsigned: zero-extend both the same way.
  - Result: A = 0 (WIDTH+2 bits), Q-ext (WIDTH+1 bits), q_1 = 0, counter = WIDTH+1.
- One CALC step per cycle:
  - Examine the pair {Q[0], q_1}: 01 gives A += M; 10 gives A −= M; 00 and 11 leave A unchanged.
  - Then arithmetic-shift {A, Q, q_1} right by 1, with A's MSB replicated.
  - Decrement the counter.
- The A guard bit prevents overflow for M = −2^(WIDTH−1). All arithmetic is modulo 2^(WIDTH+2).
- On the final step, `product` is loaded with the low 2*WIDTH bits of the shifted {A, Q}, and `done` is set.
- `start` while `busy`=1 is ignored; inputs are not re-sampled and no error is flagged.
- Operand inputs may change freely after the accept edge.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0; state is IDLE; counter, A, Q and q_1 are 0.
- Reset during CALC aborts the operation. No `done` follows, and `product` reads 0.
- Accept edge = e0. `busy` is high from e0 through e(WIDTH+1). `done`=1 for exactly one cycle after e(WIDTH+1).
- Latency: WIDTH+1 cycles from accept edge to `done`. For WIDTH=4 that is 5 cycles.
- Throughput: `start` held high in the DONE cycle is accepted at once. Back-to-back issue costs WIDTH+2 cycles per result.
- `done` and `busy` are never high in the same cycle.
- `RST` and `start` asserted on the same edge: `RST` wins.

## Structure
- Package `booth_pkg`:
  - state enum `booth_state_t` (IDLE, CALC, DONE)
  - Booth pair constants `BOOTH_ADD`=2'b01 and `BOOTH_SUB`=2'b10
  - helper width function for the counter, `$clog2(WIDTH+2)`.
- Sub-module `booth_step`: purely combinational and parametrised by WIDTH. Takes {A, Q, q_1} and M, and returns the next {A, Q, q_1} (add/subtract, then arithmetic shift).
- The top level holds the FSM, counter, operand registers and product register.

## Test plan
- WIDTH=4, signed: 4'b1111 × 4'b1111 → `product`=8'h01, with `done` exactly 5 cycles after the accept edge.
- WIDTH=4, unsigned, same operands → `product`=8'hE1 (225). WIDTH=4, signed, 4'b1111 × 4'b0010 → 8'hFE (−2).
- Corner operands:
  - WIDTH=4 signed: 4'b1000 × 4'b1000 → 8'h40.
  - WIDTH=8 signed: 8'h80 × 8'h80 → 16'h4000.
  - WIDTH=8 unsigned: 8'hFF × 8'hFF → 16'hFE01.
- WIDTH=4:
  - Pulse `start` again mid-CALC with different operands → ignored; the first result is unaffected.
  - Then hold `start` high through DONE → second operation accepted; second `done` comes 6 cycles after the first.
- Assert `RST` for one cycle during CALC → `busy`, `done` and `product` are 0 on the next cycle. No `done` pulse follows, and a fresh `start` completes correctly.
- Randomised: WIDTH ∈ {4, 8, 16}, 1000 operand/mode triples checked against a reference `*` in a scoreboard. `product` must stay stable between `done` pulses.
